uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//  Byte buffer directly downstream of uart_rx. Accepts each received byte via
//  uart_rx's level-valid / ready-pulse handshake and stores it in a circular FIFO.
//  Presents the bytes to a consumer (command parser, LED logic) on a
//  valid/ready stream, so bursts at line rate are not lost while the consumer is busy.
// PARAMETERS
//  DATA_W      8   width of one stored byte/word
//  DEPTH_LOG2  4   log2 of FIFO depth (default 16 entries)
// PORTS
//  i_clk          in   1             system clock (16 MHz on board)
//  i_rst_n        in   1             asynchronous, active-low reset
//  i_rx_data      in   DATA_W        byte from uart_rx o_byte_out
//  i_rx_valid     in   1             uart_rx o_data_valid; level, held until acked
//  o_rx_ready     out  1             one-cycle ack pulse to uart_rx i_rx_ready
//  o_rd_data      out  DATA_W        head-of-FIFO byte (show-ahead)
//  o_rd_valid     out  1             FIFO not empty
//  i_rd_ready     in   1             consumer pops head when o_rd_valid & i_rd_ready
//  o_count        out  DEPTH_LOG2+1  current occupancy, 0..2**DEPTH_LOG2
//  o_full         out  1             o_count == 2**DEPTH_LOG2
//  o_overrun      out  1             sticky: a byte was dropped because FIFO was full
//  i_clr_overrun  in   1             clears o_overrun (and counter, see CONFIGURATION)
// BEHAVIOUR
//  Reset (async on i_rst_n low): wr/rd pointers=0, o_count=0, o_rd_valid=0,
//   o_full=0, o_rx_ready=0, o_overrun=0, FSM=IDLE; storage contents not reset.
//  Write FSM, two states:
//   IDLE: if i_rx_valid=1 -> capture i_rx_data (push if accepted), drive o_rx_ready=1
//         for exactly one cycle (registered, asserts the cycle after valid seen),
//         go WAIT_DROP.
//   WAIT_DROP: o_rx_ready=0; stay until i_rx_valid=0, then IDLE. Prevents a second
//         capture of the same byte while uart_rx deasserts valid one cycle late.
//  Push accepted when !o_full OR a pop occurs in the same cycle (full+pop+push:
//   count stays 2**DEPTH_LOG2, both pointers advance). Otherwise byte dropped,
//   o_overrun set; o_rx_ready still pulsed so uart_rx never stalls.
//  Read side: o_rd_data = mem[rd_ptr], valid combinationally whenever o_rd_valid=1;
//   pop advances rd_ptr next edge. i_rd_ready while empty is ignored.
//  Push to empty FIFO: o_rd_valid=1 the cycle after the push edge (latency 1 from
//   capture; 2 cycles from i_rx_valid rising).
//  Simultaneous push+pop, non-full non-empty: count unchanged.
//  Pointers DEPTH_LOG2 bits, wrap naturally modulo depth; count tracked separately.
//  i_clr_overrun has priority over a same-cycle new overrun (clear wins).
//  Reset mid-handshake: FSM to IDLE, o_rx_ready=0; a byte still held valid by
//   uart_rx after reset release is captured as a new byte.
// CONFIGURATION
//  UART_RX_FIFO_OVERRUN_CNT_EN defined: adds port o_overrun_cnt out 8, counting
//   dropped bytes, saturating at 255, reset to 0, cleared by i_clr_overrun.
//  Not defined: port absent, no counter logic; only sticky o_overrun exists.
// TESTING
//  1 Reset, send "A" (0x41) via valid/ready model -> one o_rx_ready pulse, o_count=1,
//    o_rd_data=0x41, o_rd_valid=1 two cycles after i_rx_valid rises.
//  2 Hold i_rx_valid high 3 cycles after ack -> exactly one push, count stays 1.
//  3 i_rd_ready=0, push 17 bytes 0x00..0x10 (DEPTH_LOG2=4) -> o_full after 16th,
//    0x10 dropped, o_overrun=1, pop order 0x00..0x0F.
//  4 Full FIFO, push 0x55 with simultaneous pop -> count stays 16, no overrun,
//    0x55 emerges last.
//  5 Push/pop 40 bytes with i_rd_ready random -> pointers wrap, output order
//    matches input order, count never exceeds 16.
//  6 With UART_RX_FIFO_OVERRUN_CNT_EN: drop 300 bytes -> o_overrun_cnt=255;
//    pulse i_clr_overrun -> o_overrun=0, o_overrun_cnt=0.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: byte-ingest handshake and consumer stream of uart_rx_fifo.
//  slave  : the FIFO side (uart_rx_fifo)
//  master : the uart_rx / consumer side (driver)
// Optional: UART_RX_FIFO_OVERRUN_CNT_EN adds o_overrun_cnt (8-bit drop counter).
interface uart_rx_fifo_if #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned DEPTH_LOG2 = 4
);
   logic [DATA_W-1:0]   i_rx_data;
   logic                i_rx_valid;
   logic                o_rx_ready;
   logic [DATA_W-1:0]   o_rd_data;
   logic                o_rd_valid;
   logic                i_rd_ready;
   logic [DEPTH_LOG2:0] o_count;
   logic                o_full;
   logic                o_overrun;
   logic                i_clr_overrun;
`ifdef UART_RX_FIFO_OVERRUN_CNT_EN
   logic [7:0]          o_overrun_cnt;
`endif

   modport slave (
      input  i_rx_data, i_rx_valid, i_rd_ready, i_clr_overrun,
      output o_rx_ready, o_rd_data, o_rd_valid, o_count, o_full, o_overrun
`ifdef UART_RX_FIFO_OVERRUN_CNT_EN
      , output o_overrun_cnt
`endif
   );

   modport master (
      output i_rx_data, i_rx_valid, i_rd_ready, i_clr_overrun,
      input  o_rx_ready, o_rd_data, o_rd_valid, o_count, o_full, o_overrun
`ifdef UART_RX_FIFO_OVERRUN_CNT_EN
      , input o_overrun_cnt
`endif
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: circular byte FIFO downstream of uart_rx.
//  Ports: i_clk, i_rst_n (async active-low), bus (uart_rx_fifo_if.slave):
//   i_rx_data/i_rx_valid/o_rx_ready : level-valid, one-cycle ack ingest
//   o_rd_data/o_rd_valid/i_rd_ready : show-ahead consumer stream
//   o_count/o_full                  : occupancy
//   o_overrun/i_clr_overrun         : sticky drop flag and its clear
// Optional: UART_RX_FIFO_OVERRUN_CNT_EN adds o_overrun_cnt, a saturating
//  count of dropped bytes cleared with o_overrun.
module uart_rx_fifo #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input logic           i_clk,
   input logic           i_rst_n,
   uart_rx_fifo_if.slave bus
);
   localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
   localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

   typedef enum logic [0:0] {IDLE, WAIT_DROP} state_t;

   state_t              state_q, state_d;
   logic                ack_q, ack_d;
   logic [DATA_W-1:0]   cap_q, cap_d;

   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                rd_valid_q, full_q, overrun_q;
   logic                pop_c, push_c, accept_c, drop_c;

   // Ingest FSM state, ack pulse and captured byte
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         ack_q   <= 1'b0;
         cap_q   <= '0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         cap_q   <= cap_d;
      end
   end

   // WAIT_DROP ignores valid until uart_rx lowers it, so one byte acks once
   always_comb begin
      state_d = state_q;
      ack_d   = 1'b0;
      cap_d   = cap_q;
      case (state_q)
         IDLE: begin
            if (bus.i_rx_valid) begin
               ack_d   = 1'b1;
               cap_d   = bus.i_rx_data;
               state_d = WAIT_DROP;
            end
         end
         WAIT_DROP: begin
            if (!bus.i_rx_valid) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // The captured byte is pushed on the ack cycle; a same-cycle pop frees a slot
   assign pop_c    = rd_valid_q & bus.i_rd_ready;
   assign push_c   = ack_q;
   assign accept_c = push_c & (~full_q | pop_c);
   assign drop_c   = push_c & ~accept_c;

   always_comb begin
      count_d = count_q;
      case ({accept_c, pop_c})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointers, occupancy and sticky overrun (clear beats a new drop)
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_valid_q <= 1'b0;
         full_q     <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         if (accept_c) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
         if (pop_c)    rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
         count_q    <= count_d;
         rd_valid_q <= (count_d != '0);
         full_q     <= (count_d == CNT_W'(DEPTH));
         if (bus.i_clr_overrun) overrun_q <= 1'b0;
         else if (drop_c)       overrun_q <= 1'b1;
      end
   end

   // Storage is not reset
   always_ff @(posedge i_clk) begin
      if (accept_c) mem_q[wr_ptr_q] <= cap_q;
   end

`ifdef UART_RX_FIFO_OVERRUN_CNT_EN
   logic [7:0] ovr_cnt_q;

   // Saturating dropped-byte counter
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                          ovr_cnt_q <= '0;
      else if (bus.i_clr_overrun)            ovr_cnt_q <= '0;
      else if (drop_c && ovr_cnt_q != 8'hFF) ovr_cnt_q <= ovr_cnt_q + 8'd1;
   end

   assign bus.o_overrun_cnt = ovr_cnt_q;
`endif

   assign bus.o_rx_ready = ack_q;
   assign bus.o_rd_data  = mem_q[rd_ptr_q];
   assign bus.o_rd_valid = rd_valid_q;
   assign bus.o_count    = count_q;
   assign bus.o_full     = full_q;
   assign bus.o_overrun  = overrun_q;
endmodule
